uart_tx_corr4: RTL and testbench



---
 rtl/uart_tx_corr4_pkg.sv | 20 ++
 rtl/uart_tx_corr4_if.sv | 12 +
 rtl/uart_tx_corr4_baud.sv | 27 ++
 rtl/uart_tx_corr4.sv | 121 ++++++++++++
 tb/tb_uart_tx_corr4.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_corr4_pkg.sv
// rtl/uart_tx_corr4_pkg.sv - shared types and constants for the uart_tx_corr4 transmitter
package uart_tx_corr4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int PRESCALE_MULT = 8;
    localparam int PRESCALE_W    = 16;
    localparam int PERIOD_W      = PRESCALE_W + $clog2(PRESCALE_MULT);

    // Frame index runs 0 (start) .. data_width+1 (stop) and must not wrap.
    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width + 2);
    endfunction

endpackage

// File: rtl/uart_tx_corr4_if.sv
// rtl/uart_tx_corr4_if.sv - stream handshake bundle feeding the transmitter
interface uart_tx_corr4_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_tx_corr4_baud.sv
// rtl/uart_tx_corr4_baud.sv - bit-period down-counter, ticks on the last cycle of each bit
module uart_tx_corr4_baud
    import uart_tx_corr4_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    input  logic                run,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period - PERIOD_W'(1);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - PERIOD_W'(1);
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/uart_tx_corr4.sv
// rtl/uart_tx_corr4.sv - stream-to-serial UART transmitter, start + DATA_WIDTH bits LSB first + stop
module uart_tx_corr4
    import uart_tx_corr4_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_corr4_if.slave        s_axis,
    output logic                  txd,
    output logic                  busy,
    input  logic [PRESCALE_W-1:0] prescale
);

    localparam int BCW = bit_cnt_width(DATA_WIDTH);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BCW-1:0]        bit_cnt;
    logic [PERIOD_W-1:0]   period_q;
    logic [PERIOD_W-1:0]   period_new;
    logic [PERIOD_W-1:0]   load_val;
    logic [PRESCALE_W-1:0] ps_eff;
    logic                  ready_en;
    logic                  accept;
    logic                  tick;
    logic                  run;
    logic                  load;
    logic                  shift;

    assign ps_eff     = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign period_new = PERIOD_W'(ps_eff) * PERIOD_W'(PRESCALE_MULT);
    assign accept     = s_axis.tvalid && s_axis.tready;
    assign run        = (state != ST_IDLE);
    assign load_val   = accept ? period_new : period_q;

    uart_tx_corr4_baud u_baud (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .period (load_val),
        .run    (run),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_START;
            ST_START: if (tick) state_nxt = ST_DATA;
            ST_DATA:  if (tick && (bit_cnt == LAST_DATA)) state_nxt = ST_STOP;
            ST_STOP:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset forces txd high at once.
    always_comb begin
        txd           = 1'b1;
        busy          = 1'b0;
        s_axis.tready = 1'b0;
        load          = 1'b0;
        shift         = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis.tready = ready_en;
                load          = accept;
            end
            ST_START: begin
                txd  = 1'b0;
                busy = 1'b1;
                load = tick;
            end
            ST_DATA: begin
                txd   = shreg[0];
                busy  = 1'b1;
                load  = tick;
                shift = tick;
            end
            ST_STOP: begin
                busy = 1'b1;
            end
            default: begin
                txd = 1'b1;
            end
        endcase
    end

    // The frame index stops at the stop bit, keeping it inside BCW bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            period_q <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                shreg    <= s_axis.tdata;
                bit_cnt  <= '0;
                period_q <= period_new;
            end else if (tick && (state != ST_STOP)) begin
                bit_cnt <= bit_cnt + BCW'(1);
                if (shift) begin
                    shreg <= shreg >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_corr4.sv
// tb/tb_uart_tx_corr4.sv - randomized bench for uart_tx_corr4 with a frame-timeline reference model
module tb_uart_tx_corr4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] td [2];
    logic        tv [2];
    logic [15:0] ps [2];
    logic        tr_o [2];
    logic        txd_o [2];
    logic        busy_o [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam int W [2] = '{16, 8};

    always #5 clk = ~clk;

    uart_tx_corr4_if #(.DATA_WIDTH(16)) ax16 ();
    uart_tx_corr4_if #(.DATA_WIDTH(8))  ax8 ();

    assign ax16.tdata  = td[0][15:0];
    assign ax16.tvalid = tv[0];
    assign tr_o[0]     = ax16.tready;
    assign ax8.tdata   = td[1][7:0];
    assign ax8.tvalid  = tv[1];
    assign tr_o[1]     = ax8.tready;

    uart_tx_corr4 #(.DATA_WIDTH(16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .s_axis   (ax16),
        .txd      (txd_o[0]),
        .busy     (busy_o[0]),
        .prescale (ps[0])
    );

    uart_tx_corr4 #(.DATA_WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .s_axis   (ax8),
        .txd      (txd_o[1]),
        .busy     (busy_o[1]),
        .prescale (ps[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Model: a frame is just (start edge, period, word); levels follow from elapsed time.
    logic        m_ready [2];
    logic        m_busy  [2];
    int          m_start [2];
    int          m_p     [2];
    logic [31:0] m_data  [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            for (int i = 0; i < 2; i++) begin
                m_ready[i] <= 1'b0;
                m_busy[i]  <= 1'b0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    if (cyc + 1 - m_start[i] == (W[i] + 2) * m_p[i]) begin
                        m_busy[i]  <= 1'b0;
                        m_ready[i] <= 1'b1;
                    end
                end else if (!m_ready[i]) begin
                    m_ready[i] <= 1'b1;
                end else if (tv[i]) begin
                    m_busy[i]  <= 1'b1;
                    m_ready[i] <= 1'b0;
                    m_start[i] <= cyc + 1;
                    m_data[i]  <= td[i];
                    m_p[i]     <= ((ps[i] == 16'd0) ? 1 : int'(ps[i])) * 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        int   t;
        int   idx;
        logic e_txd;
        for (int i = 0; i < 2; i++) begin
            e_txd = 1'b1;
            if (m_busy[i]) begin
                t   = cyc - m_start[i];
                idx = t / m_p[i];
                if (idx == 0) e_txd = 1'b0;
                else if (idx <= W[i]) e_txd = m_data[i][idx-1];
            end
            check_val($sformatf("mon_txd%0d", i), 32'(txd_o[i]), 32'(e_txd));
            check_val($sformatf("mon_busy%0d", i), 32'(busy_o[i]), 32'(m_busy[i]));
            check_val($sformatf("mon_tready%0d", i), 32'(tr_o[i]), 32'(m_ready[i]));
        end
    end

    task automatic wait_ready(input int i, input logic val, input int limit);
        int n;
        n = 0;
        while (tr_o[i] !== val && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tr_o[i] !== val) check_val("wait_tready_timeout", 32'(tr_o[i]), 32'(val));
    endtask

    task automatic send(input int i, input logic [31:0] d, input logic [15:0] p, output int e0);
        wait_ready(i, 1'b1, 5000);
        td[i] = d;
        ps[i] = p;
        tv[i] = 1'b1;
        wait_ready(i, 1'b0, 10);
        e0    = cyc;
        tv[i] = 1'b0;
    endtask

    initial begin
        int          e0;
        int          e1;
        int          n;
        int          bcnt;
        int          trans;
        logic        prev;
        logic [31:0] d;
        for (int i = 0; i < 2; i++) begin
            td[i] = '0;
            tv[i] = 1'b0;
            ps[i] = 16'd1;
        end

        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("rst_txd", 32'(txd_o[0]), 32'd1);
        check_val("rst_busy", 32'(busy_o[0]), 32'd0);
        check_val("rst_tready", 32'(tr_o[0]), 32'd0);
        rst = 1'b0;
        #1;
        check_val("tready_before_clk", 32'(tr_o[1]), 32'd0);
        @(posedge clk);
        #1;
        check_val("tready_after_rst", 32'(tr_o[0]), 32'd1);
        check_val("tready_after_rst8", 32'(tr_o[1]), 32'd1);

        // Long 16-bit frame
        send(0, 32'h0000_BEEF, 16'd6, e0);
        prev  = 1'b1;
        bcnt  = 0;
        trans = 0;
        n     = 0;
        while (n < 2500) begin
            @(negedge clk);
            n++;
            if (busy_o[0]) bcnt++;
            if (txd_o[0] !== prev) trans++;
            prev = txd_o[0];
            if (!busy_o[0]) break;
        end
        check_val("long_in_bound", 32'(n < 2500), 32'd1);
        check_val("long_busy_cycles", 32'(bcnt), 32'd864);
        check_val("long_transitions", 32'(trans), 32'd8);

        // 8-bit frame, prescale 1
        send(1, 32'h55, 16'd1, e0);
        wait_ready(1, 1'b1, 200);
        check_val("tready_return_80", 32'(cyc - e0), 32'd80);

        // Back-to-back with tvalid held
        wait_ready(1, 1'b1, 200);
        ps[1] = 16'd1;
        td[1] = 32'hA5;
        tv[1] = 1'b1;
        wait_ready(1, 1'b0, 10);
        e0    = cyc;
        td[1] = 32'h3C;
        wait_ready(1, 1'b1, 200);
        wait_ready(1, 1'b0, 10);
        e1    = cyc;
        tv[1] = 1'b0;
        check_val("b2b_gap", 32'(e1 - e0), 32'd81);
        wait_ready(1, 1'b1, 200);

        // Mid-frame prescale/data change
        d = $urandom;
        send(0, d, 16'd1, e0);
        repeat (20) @(posedge clk);
        #1;
        ps[0] = 16'd5;
        td[0] = ~d;
        wait_ready(0, 1'b1, 1000);
        check_val("midchg_frame_len", 32'(cyc - e0), 32'd144);

        // Randomized frames, prescale 0 included
        for (int k = 0; k < 8; k++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            send(sel, $urandom, 16'($urandom_range(0, 2)), e0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            ps[sel] = 16'($urandom_range(0, 3));
            td[sel] = $urandom;
            wait_ready(sel, 1'b1, 1000);
        end

        // Reset during DATA
        send(0, $urandom, 16'd2, e0);
        repeat (3 * 16 + 5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("midrst_txd", 32'(txd_o[0]), 32'd1);
        check_val("midrst_busy", 32'(busy_o[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(0, $urandom, 16'd1, e0);
        wait_ready(0, 1'b1, 1000);
        check_val("after_rst_frame_len", 32'(cyc - e0), 32'd144);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
